// File: rtl/dt_est_pkg.sv
// Shared types and helpers for the multi-channel dT EMA estimator.
package dt_est_pkg;

  localparam int ALPHA_SHIFT = 8;
  localparam int DEF_W       = 8;
  localparam int DEF_FRAC    = 7;
  localparam int DEF_EW      = DEF_W + DEF_FRAC + 2;

  // Per-channel state; field widths follow the default W/FRAC.
  typedef struct packed {
    logic signed [DEF_W-1:0]  t_prev;
    logic signed [DEF_EW-1:0] ema;
    logic [3:0]               cnt;
    logic                     primed;
  } dt_state_t;

  function automatic logic signed [DEF_W-1:0] q_to_int_rtz(input logic signed [DEF_EW-1:0] q);
    logic signed [DEF_EW-1:0] biased;
    biased = q + (q[DEF_EW-1] ? DEF_EW'((1 << DEF_FRAC) - 1) : '0);
    return DEF_W'(biased >>> DEF_FRAC);
  endfunction

endpackage

// File: rtl/dt_ema_core.sv
// Combinational EMA update for one primed sample: scaled delta, weighted
// blend with the previous EMA, symmetric clamp and integer conversion.
module dt_ema_core
  import dt_est_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC,
  parameter int KMAX = 7,
  localparam int EW  = W + FRAC + 2
) (
  input  logic signed [W-1:0]  t,
  input  logic signed [W-1:0]  t_prev,
  input  logic signed [EW-1:0] ema,
  input  logic [7:0]           alpha,
  input  logic [7:0]           k_dt,
  input  logic [W-2:0]         d_max,
  output logic signed [EW-1:0] ema_nxt,
  output logic signed [W-1:0]  dt,
  output logic                 sat
);

  localparam int PW = EW + 9;

  logic signed [W:0]    delta;
  logic [7:0]           ksh;
  logic signed [EW-1:0] d;
  logic signed [EW-1:0] e;
  logic signed [EW-1:0] lim;
  logic signed [PW-1:0] w_new;
  logic signed [PW-1:0] w_old;
  logic signed [PW-1:0] acc;

  always_comb begin
    delta   = {t[W-1], t} - {t_prev[W-1], t_prev};
    ksh     = (k_dt > 8'(KMAX)) ? 8'(KMAX) : k_dt;
    d       = EW'(delta) <<< FRAC;
    d       = d >>> ksh;
    w_new   = PW'(alpha);
    w_old   = PW'(1 << ALPHA_SHIFT) - w_new;
    // Floor of the blend: arithmetic shift of a signed accumulator.
    acc     = PW'(ema) * w_old + PW'(d) * w_new;
    e       = EW'(acc >>> ALPHA_SHIFT);
    lim     = EW'(d_max) <<< FRAC;
    ema_nxt = e;
    sat     = 1'b0;
    if (e > lim) begin
      ema_nxt = lim;
      sat     = 1'b1;
    end else if (e < -lim) begin
      ema_nxt = -lim;
      sat     = 1'b1;
    end
    dt = q_to_int_rtz(ema_nxt);
  end

endmodule

// File: rtl/dt_estimator_mc.sv
// Time-multiplexed dT EMA estimator: per-channel state array, valid/ready
// handshake with a single registered result stage, and warm-up tracking.
module dt_estimator_mc
  import dt_est_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int W      = DEF_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int KMAX   = 7,
  parameter int WARMUP = 2,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int EW    = W + FRAC + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          alpha,
  input  logic [7:0]          k_dt,
  input  logic [W-2:0]        d_max,
  input  logic [N_CH-1:0]     init_mask,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH_W-1:0]     s_ch,
  input  logic signed [W-1:0] s_T,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CH_W-1:0]     m_ch,
  output logic signed [W-1:0] m_dT,
  output logic                m_sat,
  output logic                m_dt_valid
);

  dt_state_t st [N_CH];
  dt_state_t rd;
  dt_state_t nxt;

  logic [(1<<CH_W)-1:0] ch_ok;
  logic                 ch_in;
  logic [CH_W-1:0]      rd_idx;
  logic                 accept;
  logic                 init_hit;
  logic                 prime;
  logic [3:0]           cnt_inc;
  logic signed [EW-1:0] core_ema;
  logic signed [W-1:0]  core_dt;
  logic                 core_sat;
  logic signed [W-1:0]  o_dt;
  logic                 o_sat;
  logic                 o_dtv;

  // Channel indices past N_CH are accepted but produce nothing.
  for (genvar g = 0; g < (1 << CH_W); g++) begin : g_ch_ok
    assign ch_ok[g] = (g < N_CH);
  end

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign ch_in    = ch_ok[s_ch];
  assign rd_idx   = ch_in ? s_ch : '0;
  assign rd       = st[rd_idx];
  assign init_hit = init_mask[rd_idx];

  dt_ema_core #(
    .W    (W),
    .FRAC (FRAC),
    .KMAX (KMAX)
  ) u_core (
    .t       (s_T),
    .t_prev  (rd.t_prev),
    .ema     (rd.ema),
    .alpha   (alpha),
    .k_dt    (k_dt),
    .d_max   (d_max),
    .ema_nxt (core_ema),
    .dt      (core_dt),
    .sat     (core_sat)
  );

  always_comb begin
    prime   = !rd.primed || init_hit;
    cnt_inc = (rd.cnt >= 4'(WARMUP)) ? 4'(WARMUP) : rd.cnt + 4'd1;
    nxt     = '{t_prev: s_T, ema: core_ema, cnt: cnt_inc, primed: 1'b1};
    o_dt    = core_dt;
    o_sat   = core_sat;
    o_dtv   = (cnt_inc >= 4'(WARMUP));
    if (prime) begin
      nxt   = '{t_prev: s_T, ema: '0, cnt: 4'd1, primed: 1'b1};
      o_dt  = '0;
      o_sat = 1'b0;
      o_dtv = (WARMUP <= 1);
    end
  end

  // State stage: an accepted sample on channel i outranks a bare init on i
  // because nxt already folds the init into a priming update.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        st[i] <= '0;
      end else if (accept && ch_in && rd_idx == CH_W'(i)) begin
        st[i] <= nxt;
      end else if (init_mask[i]) begin
        st[i] <= '0;
      end
    end
  end

  // Result stage
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_ch       <= '0;
      m_dT       <= '0;
      m_sat      <= 1'b0;
      m_dt_valid <= 1'b0;
    end else if (accept) begin
      m_valid <= ch_in;
      if (ch_in) begin
        m_ch       <= s_ch;
        m_dT       <= o_dt;
        m_sat      <= o_sat;
        m_dt_valid <= o_dtv;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dt_estimator_mc.sv
// Bench for dt_estimator_mc: directed vector table, hand-written handshake
// and reset sequences, then randomized traffic against an arithmetic model.
module tb_dt_estimator_mc;

  localparam int N_CH   = 4;
  localparam int W      = 8;
  localparam int KMAX   = 7;
  localparam int WARMUP = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          alpha;
  logic [7:0]          k_dt;
  logic [W-2:0]        d_max;
  logic [N_CH-1:0]     init_mask;
  logic                s_valid;
  logic                s_ready;
  logic [1:0]          s_ch;
  logic signed [W-1:0] s_T;
  logic                m_valid;
  logic                m_ready;
  logic [1:0]          m_ch;
  logic signed [W-1:0] m_dT;
  logic                m_sat;
  logic                m_dt_valid;

  always #5 clk = ~clk;

  dt_estimator_mc #(
    .N_CH   (N_CH),
    .W      (W),
    .FRAC   (7),
    .KMAX   (KMAX),
    .WARMUP (WARMUP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alpha      (alpha),
    .k_dt       (k_dt),
    .d_max      (d_max),
    .init_mask  (init_mask),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_ch       (s_ch),
    .s_T        (s_T),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_ch       (m_ch),
    .m_dT       (m_dT),
    .m_sat      (m_sat),
    .m_dt_valid (m_dt_valid)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int ch; int t; int alpha; int k; int dmax; int init; int rst_before;
    int dt; int sat; int dtv;
  } vec_t;

  vec_t vecs[$];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; init_mask = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input vec_t v, input string tag);
    @(negedge clk);
    s_valid = 1'b1; s_ch = 2'(v.ch); s_T = 8'(v.t); alpha = 8'(v.alpha);
    k_dt = 8'(v.k); d_max = 7'(v.dmax); init_mask = 4'(v.init); m_ready = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0; init_mask = '0;
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_ch"}, m_ch, v.ch);
    chk({tag, "_dT"}, m_dT, v.dt);
    chk({tag, "_sat"}, m_sat, v.sat);
    chk({tag, "_dtv"}, m_dt_valid, v.dtv);
  endtask

  // Reference model: per-channel state as plain integers.
  int mtp[N_CH], mema[N_CH], mcnt[N_CH];
  bit mpr[N_CH];

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      mtp[i] = 0; mema[i] = 0; mcnt[i] = 0; mpr[i] = 0;
    end
  endtask

  task automatic model_step(input bit acc, input int ch, input int t, input int a,
                            input int k, input int dm, input int init,
                            output int dt, output int sat, output int dtv);
    int kk, d, e, lim;
    dt = 0; sat = 0; dtv = 0;
    for (int i = 0; i < N_CH; i++)
      if (init[i] && !(acc && i == ch)) begin
        mpr[i] = 0; mtp[i] = 0; mema[i] = 0; mcnt[i] = 0;
      end
    if (acc) begin
      if (!mpr[ch] || init[ch]) begin
        mtp[ch] = t; mema[ch] = 0; mcnt[ch] = 1; mpr[ch] = 1;
        dtv = (WARMUP <= 1);
      end else begin
        kk = (k > KMAX) ? KMAX : k;
        d = floor_div((t - mtp[ch]) * 128, 1 << kk);
        e = floor_div(mema[ch] * (256 - a) + d * a, 256);
        lim = dm * 128;
        if (e > lim) begin e = lim; sat = 1; end
        else if (e < -lim) begin e = -lim; sat = 1; end
        dt = e / 128;
        mema[ch] = e; mtp[ch] = t;
        mcnt[ch] = (mcnt[ch] + 1 > WARMUP) ? WARMUP : mcnt[ch] + 1;
        dtv = (mcnt[ch] >= WARMUP);
      end
    end
  endtask

  initial begin
    int e_ch, e_dt, e_sat, e_dtv, e_mv;
    int r_dt, r_sat, r_dtv;
    bit acc;
    vec_t v;

    rst = 1'b1; alpha = '0; k_dt = '0; d_max = '0; init_mask = '0;
    s_valid = 1'b0; s_ch = '0; s_T = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_ch", m_ch, 0);
    chk("rst_dT", m_dT, 0);
    chk("rst_sat", m_sat, 0);
    chk("rst_dtv", m_dt_valid, 0);
    chk("rst_s_ready", s_ready, 1);

    //              ch  T    a    k   dm  init rst  dT sat dtv
    vecs.push_back('{0,  20, 128, 0, 100, 0, 0,  0, 0, 0});
    vecs.push_back('{0,  30, 128, 0, 100, 0, 0,  5, 0, 1});
    vecs.push_back('{0,  30, 128, 0, 100, 0, 0,  2, 0, 1});
    vecs.push_back('{0,  10, 128, 0, 100, 0, 0, -8, 0, 1});
    vecs.push_back('{1,   0, 255, 0,   3, 0, 0,  0, 0, 0});
    vecs.push_back('{1,  50, 255, 0,   3, 0, 0,  3, 1, 1});
    vecs.push_back('{1,  50, 255, 0,   3, 0, 0,  0, 0, 1});
    vecs.push_back('{0,  10, 128, 0, 100, 0, 1,  0, 0, 0});
    vecs.push_back('{2, -40, 128, 0, 100, 0, 0,  0, 0, 0});
    vecs.push_back('{0,  14, 128, 0, 100, 0, 0,  2, 0, 1});
    vecs.push_back('{2, -44, 128, 0, 100, 0, 0, -2, 0, 1});
    vecs.push_back('{1,   5, 128, 0, 100, 0, 0,  0, 0, 0});
    vecs.push_back('{1,   9, 128, 0, 100, 0, 0,  2, 0, 1});
    vecs.push_back('{0,  77, 128, 0, 100, 1, 0,  0, 0, 0});
    vecs.push_back('{0,  77, 128, 0, 100, 0, 0,  0, 0, 1});
    vecs.push_back('{1,   9, 128, 0, 100, 0, 0,  1, 0, 1});
    vecs.push_back('{2,  -4,  64, 2, 100, 0, 0,  1, 0, 1});
    vecs.push_back('{2, 100, 255, 200, 0, 0, 0,  0, 1, 1});
    vecs.push_back('{2, -100, 255, 0,  5, 0, 0, -5, 1, 1});

    foreach (vecs[i]) begin
      if (vecs[i].rst_before != 0) do_reset();
      send(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: pending ch2 result must hold while a ch3 sample waits.
    @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b1; s_ch = 2'd3; s_T = 8'sd1;
    alpha = 8'd128; k_dt = 8'd0; d_max = 7'd100;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_s_ready", c), s_ready, 0);
      chk($sformatf("hold%0d_valid", c), m_valid, 1);
      chk($sformatf("hold%0d_ch", c), m_ch, 2);
      chk($sformatf("hold%0d_dT", c), m_dT, -5);
      chk($sformatf("hold%0d_sat", c), m_sat, 1);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel0_valid", m_valid, 1);
    chk("rel0_ch", m_ch, 3);
    chk("rel0_dT", m_dT, 0);
    chk("rel0_dtv", m_dt_valid, 0);
    s_T = 8'sd3;
    @(posedge clk);
    #1;
    chk("rel1_valid", m_valid, 1);
    chk("rel1_ch", m_ch, 3);
    chk("rel1_dT", m_dT, 1);
    chk("rel1_dtv", m_dt_valid, 1);
    s_valid = 1'b0;

    // Reset while a result is stalled.
    @(negedge clk);
    m_ready = 1'b0; rst = 1'b1; s_valid = 1'b1; s_ch = 2'd0; s_T = 8'sd50;
    @(posedge clk);
    #1 rst = 1'b0; s_valid = 1'b0;
    chk("mrst_valid", m_valid, 0);
    chk("mrst_ch", m_ch, 0);
    chk("mrst_dT", m_dT, 0);
    chk("mrst_sat", m_sat, 0);
    chk("mrst_dtv", m_dt_valid, 0);
    chk("mrst_s_ready", s_ready, 1);
    v = '{0, 50, 128, 0, 100, 0, 0, 0, 0, 0};
    send(v, "post_rst0");
    v = '{0, 60, 128, 0, 100, 0, 0, 5, 0, 1};
    send(v, "post_rst1");

    // Randomized traffic with random backpressure and init pulses.
    do_reset();
    model_clear();
    e_mv = 0; e_ch = 0; e_dt = 0; e_sat = 0; e_dtv = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      s_valid   = ($urandom_range(0, 3) != 0);
      s_ch      = 2'($urandom_range(0, N_CH - 1));
      s_T       = 8'($urandom);
      alpha     = 8'($urandom);
      k_dt      = 8'($urandom_range(0, 10));
      d_max     = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 4)) : 7'($urandom);
      init_mask = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'd0;
      m_ready   = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_s_ready", s_ready, (e_mv == 0 || m_ready) ? 1 : 0);
      acc = s_valid && (e_mv == 0 || m_ready);
      model_step(acc, int'(s_ch), int'(s_T), int'(alpha), int'(k_dt), int'(d_max),
                 int'(init_mask), r_dt, r_sat, r_dtv);
      if (acc) begin
        e_mv = 1; e_ch = int'(s_ch); e_dt = r_dt; e_sat = r_sat; e_dtv = r_dtv;
      end else if (m_ready) begin
        e_mv = 0;
      end
      @(posedge clk);
      #1;
      init_mask = '0;
      chk("rnd_valid", m_valid, e_mv);
      if (e_mv != 0) begin
        chk("rnd_ch", m_ch, e_ch);
        chk("rnd_dT", m_dT, e_dt);
        chk("rnd_sat", m_sat, e_sat);
        chk("rnd_dtv", m_dt_valid, e_dtv);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
